cdb_arbiter: RTL and testbench
==============================

// Module: cdb_arbiter
// PURPOSE
// - Merges ALU and load-unit results onto one registered common data bus (CDB) broadcast to RS, SLB, ROB, dispatcher.
// - Per-source FIFO absorbs contention; round-robin grant, one result per cycle; flushed on rollback.
// - Sits between the execute units and all CDB consumers.
// PARAMETERS
// - DEPTH      4   entries per source FIFO (power of 2, >=2)
// - ROB_IDX_W  4   ROB index width (matches ROB_IDX_TP)
// - WORD_W     32  result width (matches WORD_TP)
// PORTS
// - clk        in   1          clock
// - rst        in   1          reset, synchronous, active-high
// - rdy        in   1          global ready; low = freeze
// - rb         in   1          rollback flush
// - alu_valid  in   1          ALU result present
// - alu_src    in   ROB_IDX_W  ROB tag of ALU result
// - alu_val    in   WORD_W     ALU result value
// - alu_full   out  1          ALU FIFO almost full; ALU must hold
// - ld_valid   in   1          load result present
// - ld_src     in   ROB_IDX_W  ROB tag of load result
// - ld_val     in   WORD_W     load result value
// - ld_full    out  1          load FIFO almost full; LSU must hold
// - cdb_valid  out  1          broadcast valid
// - cdb_src    out  ROB_IDX_W  broadcast ROB tag
// - cdb_val    out  WORD_W     broadcast value
// - cdb_is_ld  out  1          1 = broadcast came from load unit
// BEHAVIOUR
// - Reset: cdb_valid=0, cdb_src=0, cdb_val=0, cdb_is_ld=0, both FIFOs empty, rr pointer=ALU; full outputs=0.
// - Priority: rst > !rdy > rb > normal.
// - !rdy: all state and outputs held; inputs ignored.
// - rb: both FIFOs emptied, in-cycle inputs dropped, next-cycle cdb_valid=0, rr pointer=ALU.
// - Candidate per source: FIFO head if non-empty, else same-cycle input (bypass) if valid, else none.
// - Grant: one candidate only -> it; both -> source named by rr pointer; rr pointer flips to other source after a contested grant only.
// - Granted candidate registered onto cdb_* next edge: latency 1 cycle uncontended; cdb_valid=0 when no candidate.
// - Non-granted valid input pushed to its FIFO; bypassed input granted is not pushed.
// - Push and pop in same cycle: count unchanged; FIFO order preserved per source (no reordering within a source).
// - cdb_valid is a 1-cycle pulse per result; no result broadcast twice or lost (except on rb).
// - full = (count >= DEPTH-1), combinational from registered count: one slot slack for producer's registered valid.
// - Valid asserted while count==DEPTH: illegal; simulation assertion fires, input dropped.
// - src==0 (ZERO_ROB_IDX) with valid: illegal; simulation assertion.
// - Pointers wrap modulo DEPTH; count width clog2(DEPTH)+1.
// STRUCTURE
// - Shared package/utils: ROB_IDX_TP, WORD_TP, ZERO_ROB_IDX, ZERO_WORD, TRUE/FALSE.
// - One sub-module: cdb_src_fifo (sync FIFO, push/pop/flush, head, count); instantiated twice.
// - Top holds candidate muxing, rr pointer, output registers.
// TESTING
// - Reset then idle: cdb_valid=0 all cycles, alu_full=ld_full=0.
// - ALU only (src=3,val=0x11) -> next cycle cdb_valid=1,src=3,val=0x11,is_ld=0; FIFO stays empty.
// - ALU(src=1) and LD(src=2) same cycle, rr=ALU -> cycle+1 src=1, cycle+2 src=2 is_ld=1; rr then=ALU again after next contest flips.
// - LD every cycle (src 1..6) with ALU every cycle -> strict ALU/LD alternation; ld_full=1 once 3 queued; per-source order preserved.
// - Queue 2 ALU + 2 LD, assert rb -> next cycle cdb_valid=0, counts=0, no stale tags broadcast later.
// - rdy=0 for 3 cycles mid-backlog -> cdb_* held, counts unchanged; resumes exact sequence after rdy=1.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// Shared types and constants for the common data bus arbiter.
// No ports; imported by cdb_src_fifo and cdb_arbiter.
package cdb_arbiter_pkg;

    localparam int ROB_IDX_W = 4;
    localparam int WORD_W    = 32;

    typedef logic [ROB_IDX_W-1:0] ROB_IDX_TP;
    typedef logic [WORD_W-1:0]    WORD_TP;

    localparam ROB_IDX_TP ZERO_ROB_IDX = '0;
    localparam WORD_TP    ZERO_WORD    = '0;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    // Round-robin pointer: which source wins the next contested cycle.
    typedef enum logic {
        RR_ALU = 1'b0,
        RR_LD  = 1'b1
    } rr_e;

endpackage

// File: rtl/cdb_src_fifo.sv
// Synchronous per-source result FIFO.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   push       write din at tail (ignored when full unless popping)
//   pop        drop the head entry (ignored when empty)
//   flush      empty the FIFO; overrides push/pop
//   din        entry to write
//   head       current head entry (undefined when count==0)
//   count      number of stored entries, 0..DEPTH
module cdb_src_fifo
    import cdb_arbiter_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 36
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_pop;
    logic             do_push;

    // A push into a full FIFO is still accepted when the head leaves the same cycle.
    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !flush && do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Merges ALU and load-unit results onto one registered common data bus.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   rdy                        global ready; low freezes all state and outputs
//   rb                         rollback: flush both FIFOs, drop in-cycle inputs
//   alu_valid/src/val, alu_full  ALU result in, back-pressure out
//   ld_valid/src/val,  ld_full   load result in, back-pressure out
//   cdb_valid/src/val/is_ld    registered broadcast
//
// rr state | meaning
// RR_ALU   | ALU wins the next contested cycle
// RR_LD    | load unit wins the next contested cycle
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 rb,
    input  logic                 alu_valid,
    input  logic [ROB_IDX_W-1:0] alu_src,
    input  logic [WORD_W-1:0]    alu_val,
    output logic                 alu_full,
    input  logic                 ld_valid,
    input  logic [ROB_IDX_W-1:0] ld_src,
    input  logic [WORD_W-1:0]    ld_val,
    output logic                 ld_full,
    output logic                 cdb_valid,
    output logic [ROB_IDX_W-1:0] cdb_src,
    output logic [WORD_W-1:0]    cdb_val,
    output logic                 cdb_is_ld
);

    localparam int PL_W  = ROB_IDX_W + WORD_W;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    rr_e              rr, rr_nxt;
    logic [PL_W-1:0]  alu_head, ld_head;
    logic [CNT_W-1:0] alu_cnt, ld_cnt;
    logic             alu_empty, ld_empty;
    logic             alu_cv, ld_cv, contested;
    logic             grant_alu, grant_ld;
    logic [PL_W-1:0]  alu_cand, ld_cand, win;
    logic             alu_push, alu_pop, ld_push, ld_pop;
    logic             advance, flush;

    assign advance   = rdy && !rb;
    assign flush     = rdy && rb;
    assign alu_empty = (alu_cnt == '0);
    assign ld_empty  = (ld_cnt == '0);
    assign alu_full  = (alu_cnt >= CNT_W'(DEPTH - 1));
    assign ld_full   = (ld_cnt >= CNT_W'(DEPTH - 1));

    always_comb begin
        alu_cv    = !alu_empty || alu_valid;
        ld_cv     = !ld_empty || ld_valid;
        // Head of queue beats the same-cycle input so per-source order is kept.
        alu_cand  = alu_empty ? {alu_src, alu_val} : alu_head;
        ld_cand   = ld_empty ? {ld_src, ld_val} : ld_head;
        contested = alu_cv && ld_cv;
        grant_alu = alu_cv && (!ld_cv || (rr == RR_ALU));
        grant_ld  = ld_cv && !grant_alu;
        win       = grant_ld ? ld_cand : alu_cand;
        alu_pop   = advance && grant_alu && !alu_empty;
        ld_pop    = advance && grant_ld && !ld_empty;
        // A bypassed input that wins goes straight to the bus, not into the FIFO.
        alu_push  = advance && alu_valid && !(grant_alu && alu_empty);
        ld_push   = advance && ld_valid && !(grant_ld && ld_empty);
    end

    always_comb begin
        rr_nxt = rr;
        if (rdy) begin
            if (rb)             rr_nxt = RR_ALU;
            else if (contested) rr_nxt = (rr == RR_ALU) ? RR_LD : RR_ALU;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) rr <= RR_ALU;
        else     rr <= rr_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cdb_valid <= FALSE;
            cdb_src   <= ZERO_ROB_IDX;
            cdb_val   <= ZERO_WORD;
            cdb_is_ld <= FALSE;
        end else if (rdy) begin
            if (rb) begin
                cdb_valid <= FALSE;
            end else begin
                cdb_valid <= grant_alu || grant_ld;
                if (grant_alu || grant_ld) begin
                    cdb_src   <= win[PL_W-1:WORD_W];
                    cdb_val   <= win[WORD_W-1:0];
                    cdb_is_ld <= grant_ld;
                end
            end
        end
    end

    cdb_src_fifo #(.DEPTH(DEPTH), .W(PL_W)) u_alu_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (alu_push),
        .pop   (alu_pop),
        .flush (flush),
        .din   ({alu_src, alu_val}),
        .head  (alu_head),
        .count (alu_cnt)
    );

    cdb_src_fifo #(.DEPTH(DEPTH), .W(PL_W)) u_ld_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (ld_push),
        .pop   (ld_pop),
        .flush (flush),
        .din   ({ld_src, ld_val}),
        .head  (ld_head),
        .count (ld_cnt)
    );

    a_alu_overflow: assert property (@(posedge clk) disable iff (rst)
        (rdy && !rb && alu_valid) |-> (alu_cnt != CNT_W'(DEPTH)));
    a_ld_overflow: assert property (@(posedge clk) disable iff (rst)
        (rdy && !rb && ld_valid) |-> (ld_cnt != CNT_W'(DEPTH)));
    a_alu_zero_tag: assert property (@(posedge clk) disable iff (rst)
        (rdy && alu_valid) |-> (alu_src != ZERO_ROB_IDX));
    a_ld_zero_tag: assert property (@(posedge clk) disable iff (rst)
        (rdy && ld_valid) |-> (ld_src != ZERO_ROB_IDX));

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst, rdy, rb;
    logic        alu_valid, ld_valid;
    logic [3:0]  alu_src, ld_src;
    logic [31:0] alu_val, ld_val;
    logic        alu_full, ld_full;
    logic        cdb_valid, cdb_is_ld;
    logic [3:0]  cdb_src;
    logic [31:0] cdb_val;

    always #5 clk = ~clk;

    cdb_arbiter #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rb(rb),
        .alu_valid(alu_valid), .alu_src(alu_src), .alu_val(alu_val), .alu_full(alu_full),
        .ld_valid(ld_valid), .ld_src(ld_src), .ld_val(ld_val), .ld_full(ld_full),
        .cdb_valid(cdb_valid), .cdb_src(cdb_src), .cdb_val(cdb_val), .cdb_is_ld(cdb_is_ld)
    );

    typedef struct packed {
        logic [3:0]  src;
        logic [31:0] val;
    } item_t;

    item_t aq[$];
    item_t lq[$];
    bit    m_rr_ld;
    bit    e_valid, e_is_ld;
    item_t e_item;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: one result per cycle, heads of queue before fresh inputs,
    // round-robin only when both sources have something to offer.
    task automatic model_step();
        bit    a_cv, l_cv, a_q, l_q, ga, gl;
        item_t a_it, l_it;
        if (rst) begin
            aq.delete(); lq.delete();
            m_rr_ld = 0; e_valid = 0; e_is_ld = 0; e_item = '0;
        end else if (!rdy) begin
            // frozen
        end else if (rb) begin
            aq.delete(); lq.delete();
            m_rr_ld = 0; e_valid = 0;
        end else begin
            a_q  = aq.size() > 0;
            l_q  = lq.size() > 0;
            a_cv = a_q || alu_valid;
            l_cv = l_q || ld_valid;
            a_it = a_q ? aq[0] : item_t'{alu_src, alu_val};
            l_it = l_q ? lq[0] : item_t'{ld_src, ld_val};
            ga = a_cv && (!l_cv || !m_rr_ld);
            gl = l_cv && !ga;
            e_valid = ga || gl;
            if (ga) begin
                e_item = a_it; e_is_ld = 0;
                if (a_q) void'(aq.pop_front());
            end else if (gl) begin
                e_item = l_it; e_is_ld = 1;
                if (l_q) void'(lq.pop_front());
            end
            if (alu_valid && !(ga && !a_q) && aq.size() < DEPTH) aq.push_back(item_t'{alu_src, alu_val});
            if (ld_valid && !(gl && !l_q) && lq.size() < DEPTH) lq.push_back(item_t'{ld_src, ld_val});
            if (a_cv && l_cv) m_rr_ld = !m_rr_ld;
        end
    endtask

    task automatic compare();
        chk("cdb_valid", 64'(cdb_valid), 64'(e_valid));
        if (e_valid) begin
            chk("cdb_src", 64'(cdb_src), 64'(e_item.src));
            chk("cdb_val", 64'(cdb_val), 64'(e_item.val));
            chk("cdb_is_ld", 64'(cdb_is_ld), 64'(e_is_ld));
        end
        chk("alu_full", 64'(alu_full), 64'(aq.size() >= DEPTH - 1));
        chk("ld_full", 64'(ld_full), 64'(lq.size() >= DEPTH - 1));
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        compare();
    endtask

    task automatic drive(input bit av, input logic [3:0] as, input logic [31:0] aval,
                         input bit lv, input logic [3:0] ls, input logic [31:0] lval);
        alu_valid = av; alu_src = as; alu_val = aval;
        ld_valid  = lv; ld_src  = ls; ld_val  = lval;
    endtask

    task automatic idle();
        drive(0, 4'd0, 32'd0, 0, 4'd0, 32'd0);
        step();
    endtask

    task automatic backlog();
        drive(1, 4'd6, 32'h60, 1, 4'd7, 32'h70);   step();
        drive(1, 4'd8, 32'h80, 1, 4'd9, 32'h90);   step();
        drive(1, 4'd10, 32'hA0, 1, 4'd11, 32'hB0); step();
        drive(1, 4'd12, 32'hC0, 1, 4'd13, 32'hD0); step();
    endtask

    bit ld_full_seen;

    initial begin
        rst = 1; rdy = 1; rb = 0;
        drive(0, 4'd0, 32'd0, 0, 4'd0, 32'd0);
        step(); step();
        chk("rst_valid", 64'(cdb_valid), 64'd0);
        chk("rst_src", 64'(cdb_src), 64'd0);
        chk("rst_val", 64'(cdb_val), 64'd0);
        chk("rst_is_ld", 64'(cdb_is_ld), 64'd0);
        chk("rst_alu_full", 64'(alu_full), 64'd0);
        chk("rst_ld_full", 64'(ld_full), 64'd0);
        rst = 0;

        for (int i = 0; i < 3; i++) begin
            idle();
            chk("idle_valid", 64'(cdb_valid), 64'd0);
        end

        // single ALU result, latency 1
        drive(1, 4'd3, 32'h11, 0, 4'd0, 32'd0); step();
        chk("alu_only_valid", 64'(cdb_valid), 64'd1);
        chk("alu_only_src", 64'(cdb_src), 64'd3);
        chk("alu_only_val", 64'(cdb_val), 64'h11);
        chk("alu_only_is_ld", 64'(cdb_is_ld), 64'd0);
        idle();
        chk("alu_only_pulse", 64'(cdb_valid), 64'd0);

        // contested: ALU first, then LD; next contest goes to LD
        drive(1, 4'd1, 32'hA1, 1, 4'd2, 32'hB2); step();
        chk("contest1_src", 64'(cdb_src), 64'd1);
        chk("contest1_is_ld", 64'(cdb_is_ld), 64'd0);
        idle();
        chk("contest2_src", 64'(cdb_src), 64'd2);
        chk("contest2_is_ld", 64'(cdb_is_ld), 64'd1);
        drive(1, 4'd4, 32'hA4, 1, 4'd5, 32'hB5); step();
        chk("contest3_src", 64'(cdb_src), 64'd5);
        chk("contest3_is_ld", 64'(cdb_is_ld), 64'd1);
        idle();
        chk("contest4_src", 64'(cdb_src), 64'd4);
        chk("contest4_is_ld", 64'(cdb_is_ld), 64'd0);
        idle();

        // rollback with 2+2 queued
        backlog();
        rb = 1;
        drive(1, 4'd14, 32'hE0, 1, 4'd15, 32'hF0); step();
        rb = 0;
        chk("rb_valid", 64'(cdb_valid), 64'd0);
        for (int i = 0; i < 4; i++) begin
            idle();
            chk("rb_no_stale", 64'(cdb_valid), 64'd0);
        end

        // freeze mid-backlog
        backlog();
        rdy = 0;
        for (int i = 0; i < 3; i++) begin
            drive(1, 4'd14, 32'hE0, 1, 4'd15, 32'hF0); step();
        end
        rdy = 1;
        for (int i = 0; i < 6; i++) idle();

        // both sources every cycle, honoring back-pressure
        ld_full_seen = 0;
        for (int i = 0; i < 16; i++) begin
            drive(!alu_full, 4'(i % 6 + 1), 32'(i), !ld_full, 4'(i % 6 + 1), 32'(i + 100));
            step();
            if (ld_full) ld_full_seen = 1;
        end
        chk("ld_full_seen", 64'(ld_full_seen), 64'd1);
        for (int i = 0; i < 10; i++) idle();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rdy = ($urandom_range(0, 9) != 0);
            rb  = ($urandom_range(0, 32) == 0);
            drive(!alu_full && ($urandom_range(0, 9) < 6), 4'($urandom_range(1, 15)), $urandom(),
                  !ld_full && ($urandom_range(0, 9) < 6), 4'($urandom_range(1, 15)), $urandom());
            step();
        end
        rdy = 1; rb = 0;
        for (int i = 0; i < 10; i++) idle();
        chk("drained_valid", 64'(cdb_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
